// File: rtl/aux_burst_sched.sv
// Aux FIFO burst read scheduler: fixed-length bursts with idle gaps outside active video, round-robin over channels.
// Optional build macro AUX_PRESENCE_EN adds per-frame audio presence tracking that masks channels off.
module aux_burst_sched #(
    parameter int CH      = 2,
    parameter int BURST   = 32,
    parameter int GAP     = 4,
    parameter int CNT_W   = 12,
    parameter int START_H = 1530,
    parameter int LEFT_W  = 4,
    localparam int SEL_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 fifo_clk,
    input  logic                 sys_rst,
    input  logic [CNT_W-1:0]     hcnt,
    input  logic [CNT_W-1:0]     vcnt,
    input  logic                 vde,
    input  logic [CH-1:0]        empty,
    input  logic [CH*LEFT_W-1:0] left,
    output logic [CH-1:0]        rd_en,
    output logic [SEL_W-1:0]     ch_sel,
    output logic                 busy,
    output logic                 underrun,
    output logic [CH-1:0]        audio_on
);

    localparam int CNT_MAX = (BURST > GAP) ? BURST : GAP;
    localparam int BC_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_READ, S_GAP} state_t;

    state_t            r_state;
    logic [BC_W-1:0]   r_cnt;
    logic [SEL_W-1:0]  r_rr_ptr;
    logic [SEL_W-1:0]  r_ch_sel;
    logic [CH-1:0]     r_rd_en;
    logic              r_busy;
    logic              r_underrun;

    logic [CH-1:0]     w_audio_on;
    logic [CH-1:0]     w_elig;
    logic [SEL_W:0]    w_arm_pick;
    logic [SEL_W:0]    w_gap_pick;
    logic [LEFT_W-1:0] w_cur_left;
    logic              w_cur_empty;
    logic              w_start_hit;

    // First eligible channel scanning upward from ptr+1 (wrapping); MSB flags a hit.
    function automatic logic [SEL_W:0] f_pick(input logic [CH-1:0] elig, input logic [SEL_W-1:0] ptr);
        logic [SEL_W:0] res;
        int             idx;
        res = '0;
        for (int k = CH; k >= 1; k--) begin
            idx = (int'(ptr) + k) % CH;
            if (elig[idx]) res = {1'b1, SEL_W'(idx)};
        end
        return res;
    endfunction

    function automatic logic [CH-1:0] f_onehot(input logic [SEL_W-1:0] s);
        return CH'(1) << s;
    endfunction

    assign w_elig      = ~empty & w_audio_on;
    assign w_arm_pick  = f_pick(w_elig, r_rr_ptr);
    assign w_gap_pick  = f_pick(w_elig, r_ch_sel);
    assign w_start_hit = (hcnt == CNT_W'(START_H));

    always_comb begin
        w_cur_left  = '0;
        w_cur_empty = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (SEL_W'(i) == r_ch_sel) begin
                w_cur_left  = left[i*LEFT_W +: LEFT_W];
                w_cur_empty = empty[i];
            end
        end
    end

    // vde is only consulted on entry from ARMED and at the gap decision, so bursts are never cut short.
    always_ff @(posedge fifo_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rr_ptr   <= SEL_W'(CH - 1);
            r_ch_sel   <= '0;
            r_rd_en    <= '0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (vde) r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (w_start_hit && !vde && w_arm_pick[SEL_W]) begin
                        r_state  <= S_READ;
                        r_cnt    <= '0;
                        r_ch_sel <= w_arm_pick[SEL_W-1:0];
                        r_rd_en  <= f_onehot(w_arm_pick[SEL_W-1:0]);
                        r_busy   <= 1'b1;
                    end
                end
                S_READ: begin
                    if (r_cnt == BC_W'(BURST - 1)) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                        r_rd_en <= '0;
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        r_rd_en    <= w_cur_empty ? '0 : f_onehot(r_ch_sel);
                        r_underrun <= w_cur_empty;
                    end
                end
                S_GAP: begin
                    if (r_cnt == BC_W'(GAP - 1)) begin
                        r_cnt <= '0;
                        if ((w_cur_left != '0) && !w_cur_empty && !vde) begin
                            r_state <= S_READ;
                            r_rd_en <= f_onehot(r_ch_sel);
                        end else begin
                            r_rr_ptr <= r_ch_sel;
                            if (!vde && w_gap_pick[SEL_W]) begin
                                r_state  <= S_READ;
                                r_ch_sel <= w_gap_pick[SEL_W-1:0];
                                r_rd_en  <= f_onehot(w_gap_pick[SEL_W-1:0]);
                            end else begin
                                r_state <= S_ARMED;
                                r_busy  <= 1'b0;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef AUX_PRESENCE_EN
    logic [CH-1:0] r_audio_on;
    logic [CH-1:0] r_seen;
    logic [CH-1:0] r_set_pend;
    logic          w_frame;

    assign w_frame = (vcnt == '0) && (hcnt == '0);

    // A set that lands on the frame cycle is carried one cycle so the clear still wins.
    always_ff @(posedge fifo_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_audio_on <= '1;
            r_seen     <= '0;
            r_set_pend <= '0;
        end else if (w_frame) begin
            r_audio_on <= r_seen;
            r_seen     <= '0;
            r_set_pend <= ~empty;
        end else begin
            r_seen     <= r_seen | ~empty | r_set_pend;
            r_set_pend <= '0;
        end
    end

    assign w_audio_on = r_audio_on;
`else
    logic w_unused_vcnt;
    assign w_unused_vcnt = ^vcnt;
    assign w_audio_on    = '1;
`endif

    assign rd_en    = r_rd_en;
    assign ch_sel   = r_ch_sel;
    assign busy     = r_busy;
    assign underrun = r_underrun;
    assign audio_on = w_audio_on;

endmodule

// File: tb/tb_aux_burst_sched.sv
// Directed bench for aux_burst_sched (CH=2, default timing); presence checks follow AUX_PRESENCE_EN.
module tb_aux_burst_sched;

    localparam int CH      = 2;
    localparam int BURST   = 32;
    localparam int GAP     = 4;
    localparam int CNT_W   = 12;
    localparam int START_H = 1530;
    localparam int LEFT_W  = 4;
    localparam int PERIOD  = BURST + GAP;

    logic                 fifo_clk = 1'b0;
    logic                 sys_rst;
    logic [CNT_W-1:0]     hcnt;
    logic [CNT_W-1:0]     vcnt;
    logic                 vde;
    logic [CH-1:0]        empty;
    logic [CH*LEFT_W-1:0] left;
    logic [CH-1:0]        rd_en;
    logic [0:0]           ch_sel;
    logic                 busy;
    logic                 underrun;
    logic [CH-1:0]        audio_on;

    int n_tests = 0;
    int n_fail  = 0;
    int m_busy, m_rd0, m_rd1, m_und, m_idle, m_first_rd1;
    int cnt;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    aux_burst_sched #(
        .CH(CH), .BURST(BURST), .GAP(GAP), .CNT_W(CNT_W), .START_H(START_H), .LEFT_W(LEFT_W)
    ) dut (
        .fifo_clk(fifo_clk), .sys_rst(sys_rst), .hcnt(hcnt), .vcnt(vcnt), .vde(vde),
        .empty(empty), .left(left), .rd_en(rd_en), .ch_sel(ch_sel), .busy(busy),
        .underrun(underrun), .audio_on(audio_on)
    );

    always #5 fifo_clk = ~fifo_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge fifo_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_init(input logic [CH-1:0] emp, input logic [CH*LEFT_W-1:0] lf);
        sys_rst = 1'b1; vde = 1'b0; hcnt = '0; vcnt = 12'd5; empty = emp; left = lf;
        step();
        sys_rst = 1'b0;
        step();
        vde = 1'b1;
        step();
        vde = 1'b0;
        step();
    endtask

    task automatic start_burst(input logic [CH-1:0] exp_rd);
        hcnt = 12'(START_H);
        step();
        hcnt = '0;
        check("start_rd_en", rd_en, exp_rd);
        check("start_busy", busy, 1);
    endtask

    // Sample index 0 is the first burst cycle; events apply before the following edge.
    task automatic measure(input int e_at, input int e_len, input int drain_at,
                           input logic [CH-1:0] drain_val, input int left_at, input int vde_at);
        int i;
        i = 0;
        m_rd0 = 0; m_rd1 = 0; m_und = 0; m_idle = 0; m_first_rd1 = -1;
        obs_q.delete();
        while (busy === 1'b1 && i < 400) begin
            if (rd_en[0]) m_rd0++;
            if (rd_en[1]) begin
                m_rd1++;
                if (m_first_rd1 < 0) m_first_rd1 = i;
            end
            if (underrun) m_und++;
            if (rd_en == '0) m_idle++;
            if (i % PERIOD == 0) obs_q.push_back(32'(ch_sel));
            if (i == e_at) empty[0] = 1'b1;
            if (i == e_at + e_len) empty[0] = 1'b0;
            if (i == left_at) left = '0;
            if (i == drain_at) empty = drain_val;
            if (i == vde_at) vde = 1'b1;
            step();
            i++;
        end
        m_busy = i;
        check("busy_end", busy, 0);
        check("burst_count", obs_q.size(), exp_q.size());
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
            check("burst_ch", obs_q[k], exp_q[k]);
    endtask

    initial begin
        sys_rst = 1'b1; hcnt = '0; vcnt = 12'd5; vde = 1'b0; empty = '1; left = '0;
        step();
        check("rst_rd_en", rd_en, 0);
        check("rst_ch_sel", ch_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        check("rst_audio_on", audio_on, 2'b11);

        // No vde after reset: IDLE must hold off every read.
        sys_rst = 1'b0; empty = '0; hcnt = 12'(START_H);
        cnt = 0;
        repeat (60) begin
            step();
            if (rd_en != '0 || busy) cnt++;
        end
        check("idle_no_vde", cnt, 0);

        // Single ch0 burst, FIFO drained during the gap.
        do_init(2'b10, 8'h00);
        exp_q = '{0};
        start_burst(2'b01);
        measure(-1, 0, 32, 2'b11, -1, -1);
        check("one_rd0", m_rd0, 32);
        check("one_rd1", m_rd1, 0);
        check("one_busy", m_busy, 36);
        check("one_idle", m_idle, 4);
        check("one_und", m_und, 0);

        // Two ch0 bursts from left, then round-robin to ch1.
        do_init(2'b00, 8'h02);
        exp_q = '{0, 0, 1};
        start_burst(2'b01);
        measure(-1, 0, 104, 2'b11, 36, -1);
        check("rr_rd0", m_rd0, 64);
        check("rr_rd1", m_rd1, 32);
        check("rr_busy", m_busy, 108);
        check("rr_idle", m_idle, 12);
        check("rr_first_rd1", m_first_rd1, 72);
        check("rr_ch_sel", ch_sel, 1);

        // ch0 goes empty for 3 edges mid-burst.
        do_init(2'b10, 8'h00);
        exp_q = '{0};
        start_burst(2'b01);
        measure(9, 3, 32, 2'b11, -1, -1);
        check("und_rd0", m_rd0, 29);
        check("und_pulses", m_und, 3);
        check("und_busy", m_busy, 36);
        check("und_idle", m_idle, 7);

        // vde rises inside a burst: the burst completes, then back to ARMED.
        do_init(2'b10, 8'h00);
        exp_q = '{0};
        start_burst(2'b01);
        measure(-1, 0, -1, 2'b11, -1, 5);
        check("vde_rd0", m_rd0, 32);
        check("vde_busy", m_busy, 36);
        hcnt = 12'(START_H);
        cnt = 0;
        repeat (10) begin
            step();
            if (busy) cnt++;
        end
        check("vde_no_restart", cnt, 0);
        hcnt = '0; vde = 1'b0;

        // Reset mid-burst on ch1, then IDLE again until vde is re-seen.
        do_init(2'b01, 8'h00);
        start_burst(2'b10);
        check("rst_mid_ch_sel_pre", ch_sel, 1);
        repeat (5) step();
        sys_rst = 1'b1;
        #1;
        check("rst_mid_rd_en", rd_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ch_sel", ch_sel, 0);
        #2;
        sys_rst = 1'b0; empty = '0; hcnt = 12'(START_H);
        cnt = 0;
        repeat (40) begin
            step();
            if (rd_en != '0) cnt++;
        end
        check("rst_reidle", cnt, 0);
        hcnt = '0;

        // Frame boundary presence update; ch1 was empty the whole frame.
        do_init(2'b10, 8'h00);
        vcnt = '0; hcnt = '0;
        step();
        vcnt = 12'd5;
`ifdef AUX_PRESENCE_EN
        check("frame_audio_on", audio_on, 2'b01);
        empty = 2'b00;
        exp_q = '{0};
        start_burst(2'b01);
        measure(-1, 0, 32, 2'b01, -1, -1);
        check("pres_rd1", m_rd1, 0);
        check("pres_busy", m_busy, 36);
        check("pres_audio_on", audio_on, 2'b01);
`else
        check("frame_audio_on", audio_on, 2'b11);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aux_burst_sched.md
# aux_burst_sched

Multi-channel auxiliary (audio) FIFO read scheduler on the pixel-clock side of the HDMI-over-Ethernet receive path. It sits between the per-channel receive aux FIFOs and the HDMI aux/data-island packer. Outside active video it issues fixed-length read bursts separated by gap cycles, starting at a programmable horizontal count. It keeps reading a channel while the FIFO head reports packets left, then moves round-robin to the next non-empty channel.

## Interface
Parameters:
- CH, 2: number of aux channels (1..8)
- BURST, 32: rd_en cycles per burst
- GAP, 4: idle cycles after each burst (≥1)
- CNT_W, 12: width of hcnt/vcnt
- START_H, 1530: hcnt value that opens the aux window
- LEFT_W, 4: width of per-channel "bursts left" field

Ports:
- fifo_clk  in  1  pixel clock; all logic on rising edge
- sys_rst  in  1  asynchronous, active-high reset
- hcnt  in  CNT_W  horizontal counter
- vcnt  in  CNT_W  vertical counter
- vde  in  1  video data enable (active region)
- empty  in  CH  per-channel aux FIFO empty
- left  in  CH*LEFT_W  per-channel bursts-left field from FIFO head; channel i occupies [i*LEFT_W +: LEFT_W]
- rd_en  out  CH  per-channel FIFO read enable (registered)
- ch_sel  out  max(1,clog2(CH))  channel currently or last served
- busy  out  1  state is READ or GAP
- underrun  out  1  one-cycle pulse: burst cycle with target FIFO empty
- audio_on  out  CH  per-channel presence flags, updated once per frame

## Operation
- States: IDLE, ARMED, READ, GAP.
- IDLE: remains here until the first cycle with vde=1 after reset, then moves to ARMED. No reads are issued before that.
- ARMED: moves to READ when all of these hold in the same cycle:
  - hcnt==START_H
  - vde==0
  - at least one eligible channel exists
- Eligible channel i: empty[i]==0 and audio_on[i]==1.
- Channel selection: the first eligible channel scanning upward from (rr_ptr+1) mod CH. rr_ptr resets to CH-1, so the first scan starts at channel 0.
- READ: lasts BURST cycles, counted 0..BURST-1.
  - rd_en[ch_sel] = ~empty[ch_sel]; all other rd_en bits are 0.
  - If empty[ch_sel]==1, rd_en is held low and underrun pulses; the cycle count still advances.
- GAP: lasts GAP cycles with rd_en all 0. Decision on the last GAP cycle:
  - If left[ch_sel]!=0, ~empty[ch_sel] and vde==0: READ on the same channel.
  - Otherwise set rr_ptr <= ch_sel, pick the next eligible channel, and go to READ. If none is eligible, or vde==1, go to ARMED.
- vde rising during READ: the current burst completes. vde is evaluated only at the GAP decision, so partial bursts never occur.
- hcnt wrap during a session has no effect. START_H is checked only in ARMED.
- Reset mid-operation: all state is lost. The block returns to IDLE and init must be re-seen.
- Reset values: rd_en=0, ch_sel=0, busy=0, underrun=0, audio_on=all 1s, state=IDLE, rr_ptr=CH-1.

## Timing
- rd_en, busy, underrun and ch_sel are registered. rd_en first goes high on the cycle after hcnt==START_H is sampled.
- One burst plus its gap occupies BURST+GAP cycles. With defaults the period is 36 cycles, with rd_en high for 32 of them.
- Back-to-back bursts on different channels also have exactly GAP idle cycles between them.
- Presence update fires on the cycle where vcnt==0 && hcnt==0:
  - audio_on[i] <= seen[i]; seen[i] is then cleared.
  - seen[i] is set on any cycle with empty[i]==0.
  - If set and clear coincide, clear wins and the set applies on the next cycle.

## Configuration
- AUX_PRESENCE_EN defined: the seen/audio_on logic is present, and channels with audio_on=0 are skipped by the scheduler.
- AUX_PRESENCE_EN undefined: the logic is removed, audio_on is constant all 1s, and eligibility depends on empty only.

## Test plan
- CH=2, defaults. Hold vde=0 after reset, empty=0 → no rd_en ever, because IDLE waits for vde.
- After one vde pulse: empty[0]=0, left0=0, empty[1]=1, hcnt→1530 → rd_en[0] high for 32 cycles starting the cycle after hcnt=1530, then 4 idle cycles, then return to ARMED.
- left0=2 then 0 at the second decision, channel 1 also non-empty → two ch0 bursts, then one ch1 burst (ch_sel=1). Each gap is exactly 4 cycles; 108 cycles total to ARMED.
- empty[0] asserted at burst cycle 10 for 3 cycles → rd_en[0] low for those 3 cycles with underrun pulsing 3 times; the burst still ends at cycle 32.
- vde rises at burst cycle 5 → the burst runs all 32 cycles, then the block goes to ARMED with no further burst.
- AUX_PRESENCE_EN defined: ch1 never non-empty during a frame → audio_on[1]=0 after vcnt=0/hcnt=0, and ch1 is skipped even if it becomes non-empty before the next update. Assert sys_rst mid-burst → rd_en=0 immediately.
